// File: rtl/aes_output_buffer.sv
// rtl/aes_output_buffer.sv - ciphertext block FIFO draining 128-bit blocks as 32-bit stream words
module aes_output_buffer #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [127:0]     i_data_output,
  input  logic             i_data_done,
  output logic             o_is_full,
  output logic [31:0]      o_word,
  output logic             o_word_valid,
  input  logic             i_word_ready,
  output logic             o_word_last,
  output logic             o_empty,
  output logic [PTR_W:0]   o_count
);

  logic [127:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [1:0]       word_idx_q, word_idx_d;
  logic             push, xfer, pop;
  logic [127:0]     head;
  logic [31:0]      word_sel;

  // Full is decoded from the registered count so a drain from full costs one bubble cycle.
  assign o_is_full    = (count_q == (PTR_W+1)'(DEPTH));
  assign o_empty      = (count_q == '0);
  assign o_count      = count_q;
  assign o_word_valid = ~o_empty;
  assign o_word_last  = o_word_valid & (word_idx_q == 2'd3);

  assign push = i_data_done & ~o_is_full;
  assign xfer = o_word_valid & i_word_ready;
  assign pop  = xfer & (word_idx_q == 2'd3);

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    word_sel = '0;
    case (word_idx_q)
      2'd0: word_sel = head[127:96];
      2'd1: word_sel = head[95:64];
      2'd2: word_sel = head[63:32];
      2'd3: word_sel = head[31:0];
      default: word_sel = '0;
    endcase
  end

  assign o_word = o_word_valid ? word_sel : 32'h0;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (xfer) word_idx_d = word_idx_q + 2'd1;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      word_idx_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
    end
  end

  // Storage is deliberately left out of reset; count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (n_rst && push) mem_q[wr_ptr_q] <= i_data_output;
  end

endmodule

// File: tb/tb_aes_output_buffer.sv
// tb/tb_aes_output_buffer.sv - scoreboard bench for aes_output_buffer with a word-queue reference model
module tb_aes_output_buffer;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         n_rst;
  logic [127:0] i_data_output;
  logic         i_data_done;
  logic         o_is_full;
  logic [31:0]  o_word;
  logic         o_word_valid;
  logic         i_word_ready;
  logic         o_word_last;
  logic         o_empty;
  logic [2:0]   o_count;

  aes_output_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .i_data_output(i_data_output),
    .i_data_done  (i_data_done),
    .o_is_full    (o_is_full),
    .o_word       (o_word),
    .o_word_valid (o_word_valid),
    .i_word_ready (i_word_ready),
    .o_word_last  (o_word_last),
    .o_empty      (o_empty),
    .o_count      (o_count)
  );

  always #5 clk = ~clk;

  // Each entry: {last flag, word}; the model is just the ordered list of words still owed.
  logic [32:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  logic        hold_q = 1'b0;
  logic [31:0] hold_word;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_blocks();
    return (exp_q.size() + 3) / 4;
  endfunction

  always @(negedge clk) begin
    if (n_rst) begin
      if (hold_q) begin
        chk("stall_valid", 64'(o_word_valid), 64'd1);
        chk("stall_word", 64'(o_word), 64'(hold_word));
      end
      if (o_word_valid && i_word_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 64'(o_word_valid), 64'd0);
        end else begin
          chk("word", 64'(o_word), 64'(exp_q[0][31:0]));
          chk("last", 64'(o_word_last), 64'(exp_q[0][32]));
          void'(exp_q.pop_front());
        end
      end
      hold_q    <= o_word_valid & ~i_word_ready;
      hold_word <= o_word;
    end else begin
      hold_q <= 1'b0;
    end
  end

  task automatic check_state();
    int b = model_blocks();
    chk("count", 64'(o_count), 64'(b));
    chk("full", 64'(o_is_full), 64'(b == DEPTH));
    chk("empty", 64'(o_empty), 64'(b == 0));
    chk("valid", 64'(o_word_valid), 64'(b != 0));
    if (b == 0) begin
      chk("idle_word", 64'(o_word), 64'd0);
      chk("idle_last", 64'(o_word_last), 64'd0);
    end
  endtask

  task automatic step(input logic done, input logic [127:0] data, input logic ready,
                      output logic pushed);
    check_state();
    i_data_done   = done;
    i_data_output = data;
    i_word_ready  = ready;
    pushed = done && (model_blocks() < DEPTH);
    if (pushed) begin
      exp_q.push_back({1'b0, data[127:96]});
      exp_q.push_back({1'b0, data[95:64]});
      exp_q.push_back({1'b0, data[63:32]});
      exp_q.push_back({1'b1, data[31:0]});
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    i_data_done = 1'b0;
    i_word_ready = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    n_rst = 1'b1;
    check_state();
  endtask

  task automatic drain();
    logic p;
    int guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      step(1'b0, 128'h0, 1'b1, p);
      guard++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    step(1'b0, 128'h0, 1'b1, p);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic p;
    int guard;
    logic [127:0] d5;
    n_rst = 1'b0;
    i_data_done = 1'b0;
    i_data_output = '0;
    i_word_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Single known block
    step(1'b1, 128'h3925841d02dc09fbdc118597196a0b32, 1'b1, p);
    drain();

    // Fill and stall, then hold a fifth block while full
    for (int i = 0; i < 4; i++) step(1'b1, rnd128(), 1'b0, p);
    d5 = rnd128();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, d5, 1'b0, p);
      chk("no_push_when_full", 64'(p), 64'd0);
    end
    p = 1'b0;
    guard = 0;
    while (!p && guard < 20) begin
      step(1'b1, d5, 1'b1, p);
      guard++;
    end
    chk("held_block_pushed", 64'(p), 64'd1);
    drain();

    // Sink back-pressure mid-block
    step(1'b1, rnd128(), 1'b0, p);
    step(1'b1, rnd128(), 1'b0, p);
    for (int i = 0; i < 24; i++) step(1'b0, 128'h0, (i % 4 == 0) || (i % 4 == 3), p);
    drain();

    // Push coinciding with a last-word pop at count 2
    step(1'b1, rnd128(), 1'b0, p);
    step(1'b1, rnd128(), 1'b0, p);
    for (int i = 0; i < 3; i++) step(1'b0, 128'h0, 1'b1, p);
    step(1'b1, rnd128(), 1'b1, p);
    chk("simul_count", 64'(o_count), 64'd2);
    drain();

    // Randomized streaming, exercises pointer wrap many times
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 2) == 0), rnd128(), ($urandom_range(0, 3) != 0), p);
    drain();

    // Reset mid-drain
    step(1'b1, rnd128(), 1'b0, p);
    step(1'b1, rnd128(), 1'b1, p);
    step(1'b0, 128'h0, 1'b1, p);
    do_reset();
    chk("rst_valid", 64'(o_word_valid), 64'd0);
    step(1'b1, rnd128(), 1'b1, p);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_output_buffer.md
Name: aes_output_buffer

Overview:
Downstream stage of the AES encryption pipeline. It captures each finished 128-bit ciphertext block when the encryption core flags completion, and stores the blocks in a small FIFO. It drains them as 32-bit words over a valid/ready stream toward the host interface. While the FIFO is full it asserts back-pressure, which freezes the encryption pipeline registers.

Parameters:
DEPTH, 4, number of 128-bit block entries; power of two, minimum 2.
PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
clk  input  1  system clock; all state updates on rising edge.
n_rst  input  1  active-low reset, synchronous: sampled on the rising edge of clk only.
i_data_output  input  128  ciphertext block from the encryption core.
i_data_done  input  1  block-complete flag from the encryption core (round state 26).
o_is_full  output  1  back-pressure to the encryption core's is_full input; high when count == DEPTH.
o_word  output  32  current output word.
o_word_valid  output  1  o_word holds valid data.
i_word_ready  input  1  downstream sink accepts o_word this cycle.
o_word_last  output  1  o_word is the final (least-significant) word of a block.
o_empty  output  1  count == 0.
o_count  output  PTR_W+1  number of blocks held, including a partially drained head block.

Behaviour:
- Reset (n_rst low at a clk edge):
  - wr_ptr, rd_ptr, count and word_idx are cleared to 0.
  - o_is_full=0, o_word_valid=0, o_word_last=0, o_empty=1, o_count=0, o_word=0.
  - Storage array is not reset.
  - Reset mid-drain discards all stored and partially sent blocks. There is no recovery of partial output.
- Push:
  - push = i_data_done & ~o_is_full.
  - On push, mem[wr_ptr] <= i_data_output and wr_ptr increments modulo DEPTH.
  - While o_is_full=1, the core holds its state, so i_data_done may remain high across many cycles. Those cycles must not push. Each distinct block is written exactly once.
  - While not full, i_data_done high on consecutive cycles represents distinct blocks, because the core advances every cycle. Each one pushes.
- Word serializer:
  - o_word_valid = ~o_empty.
  - o_word = slice of mem[rd_ptr] selected by word_idx. word_idx 0 gives bits [127:96], 1 gives [95:64], 2 gives [63:32], 3 gives [31:0].
  - o_word_last = o_word_valid & (word_idx == 3).
  - o_word is 0 when o_word_valid=0.
  - Transfer = o_word_valid & i_word_ready. On a transfer word_idx increments.
  - On a transfer with word_idx == 3: word_idx wraps to 0, rd_ptr increments modulo DEPTH, and pop=1.
  - o_word and o_word_valid must stay stable while o_word_valid=1 and i_word_ready=0.
- Count:
  - count_next = count + push - pop.
  - Simultaneous push and pop leaves count unchanged.
  - Push is impossible when full, so overflow cannot occur.
  - Pop is impossible when empty, because o_word_valid=0.
- Full:
  - o_is_full is decoded from the registered count, not from push/pop.
  - A pop from full clears o_is_full the cycle after the last-word transfer. The core can push again from that edge onward.
  - This gives one cycle of bubble after drain from full; that bubble is required.
- Latency:
  - A block pushed at edge N is visible as o_word (word 0) in cycle N+1 when the FIFO was empty.
  - Minimum drain rate is 4 cycles per block with i_word_ready held high.
- Pointer wrap: wr_ptr and rd_ptr wrap from DEPTH-1 to 0. Full/empty are decided by count only.

Test Plan:
- Single block: reset, then one cycle of i_data_done=1 with i_data_output=3925841d02dc09fbdc118597196a0b32 and i_word_ready=1 -> words 3925841d, 02dc09fb, dc118597, 196a0b32 on 4 consecutive cycles; o_word_last only on 196a0b32; then o_empty=1.
- Fill and stall: i_word_ready=0, push 4 distinct blocks on consecutive cycles -> o_is_full=1 and o_count=4. Then hold i_data_done=1 for 10 more cycles with a 5th value -> o_count stays 4 and the 5th value is not stored.
- Release from full: with the FIFO full, raise i_word_ready -> o_is_full drops the cycle after the 4th word transfer. The held 5th block is pushed once, and exactly 5 blocks (20 words) emerge in order.
- Sink back-pressure: toggle i_word_ready 1,0,0,1,... mid-block -> o_word stays constant while not ready; no word is duplicated or skipped.
- Simultaneous push/pop: with o_count=2, push on the same cycle as a last-word transfer -> o_count stays 2; with 6+ blocks streamed, pointer wrap preserves order.
- Reset mid-drain: assert n_rst low after word 1 of a block -> next cycle o_word_valid=0, o_count=0, o_is_full=0; a new block after reset starts at word 0.
